fp_div_pipe_mc: RTL and testbench

//  Multi-lane, stallable, pipelined floating-point divider for the vector engine (RMSnorm 1/rms scaling,

---
 rtl/fp_div_pipe_mc.sv | 231 +++++++++++++++++++++++
 tb/tb_fp_div_pipe_mc.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_div_pipe_mc.sv
// rtl/fp_div_pipe_mc.sv - multi-lane stallable pipelined floating-point divider
//
// Purpose: LANES independent floating-point divides (round-to-nearest-even) per beat,
// followed by STAGES retiming stages that all stall together under valid/ready
// backpressure. Each beat carries an ID tag and a per-lane mask. A synchronous flush
// drops every in-flight beat, and a registered counter reports how many beats are held.
// Divider behaviour: denormal operands are read as zero and NaN operands as infinity;
// results below the normal range flush to zero. Invalid operations (0/0, inf/inf)
// return infinity when IEEE_COMPLIANCE=0 and a quiet NaN otherwise.
//
// Optional feature macro: FP_DIV_STATUS_EN (adds out_status and out_dz_any).
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous flush of all in-flight beats
//   in_valid/in_ready input handshake
//   in_a, in_b        packed dividends/divisors, lane k = [k*FW +: FW]
//   in_mask           1 = lane active, 0 = lane result forced to 0
//   in_id             tag returned unchanged with the result
//   out_valid/out_ready output handshake
//   out_z, out_id     quotients and tag of the last stage
//   inflight          number of valid beats held in the stages
//   out_status        (FP_DIV_STATUS_EN) per-lane status byte, 8 bits per lane
//   out_dz_any        (FP_DIV_STATUS_EN) any lane divide-by-zero on a valid beat
module fp_div_pipe_mc #(
    parameter int SIG_WIDTH       = 23,
    parameter int EXP_WIDTH       = 8,
    parameter int IEEE_COMPLIANCE = 0,
    parameter int LANES           = 4,
    parameter int STAGES          = 5,
    parameter int ID_WIDTH        = 4
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic                                         flush,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [LANES*(SIG_WIDTH+EXP_WIDTH+1)-1:0]     in_a,
    input  logic [LANES*(SIG_WIDTH+EXP_WIDTH+1)-1:0]     in_b,
    input  logic [LANES-1:0]                             in_mask,
    input  logic [ID_WIDTH-1:0]                          in_id,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [LANES*(SIG_WIDTH+EXP_WIDTH+1)-1:0]     out_z,
    output logic [ID_WIDTH-1:0]                          out_id,
    output logic [$clog2(STAGES+1)-1:0]                  inflight
`ifdef FP_DIV_STATUS_EN
    ,
    output logic [LANES*8-1:0]                           out_status,
    output logic                                         out_dz_any
`endif
);

    localparam int FW   = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int M    = SIG_WIDTH + 1;
    localparam int EMAX = (1 << EXP_WIDTH) - 1;
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int CW   = $clog2(STAGES + 1);

    // Returns {status[7:0], quotient[FW-1:0]}.
    // Status bits: 0 zero, 1 infinity, 2 invalid, 3 tiny, 4 huge, 5 inexact, 7 divide-by-zero.
    function automatic logic [FW+7:0] fdiv(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic                 s;
        logic [EXP_WIDTH-1:0] ea, eb, ez;
        logic                 a_zero, b_zero, a_inf, b_inf;
        logic [M-1:0]         ma, mb, mant, r;
        logic [2*M+1:0]       num, den;
        logic [M+2:0]         q;
        logic [M:0]           mr;
        logic [SIG_WIDTH-1:0] frac;
        logic                 g, stk, rup;
        logic [7:0]           st;
        logic [FW-1:0]        z;
        int                   ex;
        s      = a[FW-1] ^ b[FW-1];
        ea     = a[FW-2:SIG_WIDTH];
        eb     = b[FW-2:SIG_WIDTH];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_inf  = &ea;
        b_inf  = &eb;
        ma     = {1'b1, a[SIG_WIDTH-1:0]};
        mb     = {1'b1, b[SIG_WIDTH-1:0]};
        // Quotient of the two 1.f significands scaled by 2^(M+2): it lies in [2^(M+1), 2^(M+3)),
        // leaving M result bits, a guard bit and a sticky bit whichever side of 1.0 it falls.
        num = {ma, {(M+2){1'b0}}};
        den = {{(M+2){1'b0}}, mb};
        q   = (M+3)'(num / den);
        r   = M'(num % den);
        if (q[M+2]) begin
            mant = q[M+2:3];
            g    = q[2];
            stk  = |{q[1:0], r};
            ex   = int'(ea) - int'(eb) + BIAS;
        end else begin
            mant = q[M+1:2];
            g    = q[1];
            stk  = |{q[0], r};
            ex   = int'(ea) - int'(eb) + BIAS - 1;
        end
        rup = g & (stk | mant[0]);
        mr  = {1'b0, mant} + {{M{1'b0}}, rup};
        // Rounding carry out of the significand: value becomes exactly 2.0, renormalise.
        if (mr[M]) begin
            frac = mr[M-1:1];
            ex   = ex + 1;
        end else begin
            frac = mr[SIG_WIDTH-1:0];
        end
        ez = EXP_WIDTH'(ex);
        if ((a_zero && b_zero) || (a_inf && b_inf)) begin
            z  = (IEEE_COMPLIANCE != 0) ? {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}}
                                        : {1'b0, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            st = 8'h04;
        end else if (a_inf) begin
            z  = {s, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            st = 8'h02;
        end else if (b_zero) begin
            z  = {s, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            st = 8'h82;
        end else if (a_zero || b_inf) begin
            z  = {s, {(FW-1){1'b0}}};
            st = 8'h01;
        end else if (ex >= EMAX) begin
            z  = {s, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            st = 8'h32;
        end else if (ex <= 0) begin
            z  = {s, {(FW-1){1'b0}}};
            st = 8'h29;
        end else begin
            z  = {s, ez, frac};
            st = {2'b00, g | stk, 5'b00000};
        end
        return {st, z};
    endfunction

    logic                   advance, accept;
    logic [STAGES-1:0]      v_q, v_d;
    logic [LANES*FW-1:0]    z_q [STAGES];
    logic [ID_WIDTH-1:0]    id_q [STAGES];
    logic [CW-1:0]          inflight_q, inflight_d;
    logic [LANES*FW-1:0]    z_d;
`ifdef FP_DIV_STATUS_EN
    logic [LANES*8-1:0]     st_q [STAGES];
    logic [LANES*8-1:0]     st_d;
`endif

    assign out_valid = v_q[STAGES-1];
    assign advance   = ~out_valid | out_ready;
    assign in_ready  = advance & ~flush;
    assign accept    = in_valid & in_ready;

    always_comb begin
        z_d = '0;
`ifdef FP_DIV_STATUS_EN
        st_d = '0;
`endif
        for (int k = 0; k < LANES; k++) begin
            z_d[k*FW +: FW] = in_mask[k] ? FW'(fdiv(in_a[k*FW +: FW], in_b[k*FW +: FW])) : '0;
`ifdef FP_DIV_STATUS_EN
            st_d[k*8 +: 8] = in_mask[k] ? 8'(fdiv(in_a[k*FW +: FW], in_b[k*FW +: FW]) >> FW) : 8'h00;
`endif
        end
    end

    // Stage valids and the occupancy count share one next-state so inflight tracks the same edge.
    always_comb begin
        v_d = v_q;
        if (flush) begin
            v_d = '0;
        end else if (advance) begin
            v_d[0] = accept;
            for (int i = 1; i < STAGES; i++) begin
                v_d[i] = v_q[i-1];
            end
        end
        inflight_d = '0;
        for (int i = 0; i < STAGES; i++) begin
            inflight_d = inflight_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q        <= '0;
            inflight_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                z_q[i]  <= '0;
                id_q[i] <= '0;
`ifdef FP_DIV_STATUS_EN
                st_q[i] <= '0;
`endif
            end
        end else begin
            v_q        <= v_d;
            inflight_q <= inflight_d;
            // Flushed beats keep their data; only the valids matter afterwards.
            if (advance && !flush) begin
                z_q[0]  <= z_d;
                id_q[0] <= in_id;
`ifdef FP_DIV_STATUS_EN
                st_q[0] <= st_d;
`endif
                for (int i = 1; i < STAGES; i++) begin
                    z_q[i]  <= z_q[i-1];
                    id_q[i] <= id_q[i-1];
`ifdef FP_DIV_STATUS_EN
                    st_q[i] <= st_q[i-1];
`endif
                end
            end
        end
    end

    assign out_z    = z_q[STAGES-1];
    assign out_id   = id_q[STAGES-1];
    assign inflight = inflight_q;

`ifdef FP_DIV_STATUS_EN
    logic dz_any;
    always_comb begin
        dz_any = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            dz_any = dz_any | st_q[STAGES-1][k*8+7];
        end
    end
    assign out_status = st_q[STAGES-1];
    assign out_dz_any = out_valid & dz_any;
`endif

endmodule

// File: tb/tb_fp_div_pipe_mc.sv
// tb/tb_fp_div_pipe_mc.sv - self-checking bench for fp_div_pipe_mc
module tb_fp_div_pipe_mc;

    localparam int LANES  = 4;
    localparam int STAGES = 5;
    localparam int FW     = 32;
    localparam int DW     = LANES * FW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_a, in_b;
    logic [3:0]      in_mask;
    logic [3:0]      in_id;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_z;
    logic [3:0]      out_id;
    logic [2:0]      inflight;
`ifdef FP_DIV_STATUS_EN
    logic [LANES*8-1:0] out_status;
    logic               out_dz_any;
`endif

    fp_div_pipe_mc #(
        .SIG_WIDTH(23), .EXP_WIDTH(8), .IEEE_COMPLIANCE(0),
        .LANES(LANES), .STAGES(STAGES), .ID_WIDTH(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_mask(in_mask), .in_id(in_id),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_id(out_id), .inflight(inflight)
`ifdef FP_DIV_STATUS_EN
        , .out_status(out_status), .out_dz_any(out_dz_any)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int max_inf = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hand-computed single-precision vectors: va / vb = vz.
    logic [31:0] va [8];
    logic [31:0] vb [8];
    logic [31:0] vz [8];
    initial begin
        va[0] = 32'h40C00000; vb[0] = 32'h40000000; vz[0] = 32'h40400000; //  6 / 2    = 3
        va[1] = 32'h3F800000; vb[1] = 32'h40800000; vz[1] = 32'h3E800000; //  1 / 4    = 0.25
        va[2] = 32'h3F800000; vb[2] = 32'h40400000; vz[2] = 32'h3EAAAAAB; //  1 / 3    (RNE)
        va[3] = 32'hC1200000; vb[3] = 32'h40800000; vz[3] = 32'hC0200000; // -10 / 4   = -2.5
        va[4] = 32'h3F800000; vb[4] = 32'h00000000; vz[4] = 32'h7F800000; //  1 / 0    = +Inf
        va[5] = 32'h00000000; vb[5] = 32'h40A00000; vz[5] = 32'h00000000; //  0 / 5    = 0
        va[6] = 32'h40000000; vb[6] = 32'hBF000000; vz[6] = 32'hC0800000; //  2 / -0.5 = -4
        va[7] = 32'h40400000; vb[7] = 32'h40000000; vz[7] = 32'h3FC00000; //  3 / 2    = 1.5
    end

    logic [DW-1:0] exp_z;

    // Reference model: ordered list of beats in flight, each with the number of advancing
    // edges it has seen. A beat is presented once it has aged STAGES-1 edges.
    typedef struct {
        int            age;
        logic [3:0]    id;
        logic [DW-1:0] z;
    } beat_t;
    beat_t mq[$];
    beat_t nb;
    logic  ev;

    always @(negedge clk) begin
        if (!rst_n) begin
            mq.delete();
            check("rst_out_valid", {127'b0, out_valid}, 0);
            check("rst_inflight", {125'b0, inflight}, 0);
            check("rst_out_z", out_z, 0);
        end else begin
            ev = (mq.size() > 0) && (mq[0].age == STAGES - 1);
            check("out_valid", {127'b0, out_valid}, {127'b0, ev});
            check("inflight", {125'b0, inflight}, DW'(mq.size()));
            check("in_ready", {127'b0, in_ready}, {127'b0, (!ev || out_ready) && !flush});
            if (ev) begin
                check("out_z", out_z, mq[0].z);
                check("out_id", {124'b0, out_id}, {124'b0, mq[0].id});
            end
            if (int'(inflight) > max_inf) max_inf = int'(inflight);
            if (flush) begin
                mq.delete();
            end else if (!ev || out_ready) begin
                if (ev) void'(mq.pop_front());
                for (int i = 0; i < mq.size(); i++) mq[i].age = mq[i].age + 1;
                if (in_valid) begin
                    nb.age = 0;
                    nb.id  = in_id;
                    nb.z   = exp_z;
                    mq.push_back(nb);
                end
            end
        end
    end

    task automatic send(input int base, input int step, input logic [3:0] mask, input logic [3:0] id);
        int  t;
        bit  acc;
        for (int k = 0; k < LANES; k++) begin
            int v;
            v = (base + k * step) % 8;
            in_a[k*FW +: FW]  = va[v];
            in_b[k*FW +: FW]  = vb[v];
            exp_z[k*FW +: FW] = mask[k] ? vz[v] : 32'h0;
        end
        in_mask  = mask;
        in_id    = id;
        in_valid = 1'b1;
        t   = 0;
        acc = 1'b0;
        while (!acc && t < 100) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end
        check("send_accept", {127'b0, acc}, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(inout int n);
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    int n;

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_mask = '0; in_id = '0; exp_z = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", {127'b0, out_valid}, 0);
        check("reset_inflight", {125'b0, inflight}, 0);
        check("reset_out_z", out_z, 0);
        check("reset_in_ready", {127'b0, in_ready}, 1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat 6/2 on all lanes.
        send(0, 0, 4'hF, 4'd3);
        n = 1;
        wait_valid(n);
        check("t1_latency", DW'(n), DW'(5));
        check("t1_z", out_z, {4{32'h40400000}});
        check("t1_id", {124'b0, out_id}, 3);
        @(posedge clk);
        #1;
        check("t1_single_cycle", {127'b0, out_valid}, 0);

        // Eight back-to-back beats mixing every vector across the lanes.
        max_inf = 0;
        for (int i = 0; i < 8; i++) send(i, 1, 4'hF, 4'(i));
        repeat (10) @(posedge clk);
        #1;
        check("t2_peak_inflight", DW'(max_inf), DW'(5));

        // Backpressure once the first result appears.
        for (int i = 0; i < 5; i++) send(i + 2, 1, 4'hF, 4'(8 + i));
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("t3_inflight_full", {125'b0, inflight}, 5);
        check("t3_in_ready", {127'b0, in_ready}, 0);
        check("t3_hold_id", {124'b0, out_id}, 8);
        out_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t3_drained", {125'b0, inflight}, 0);

        // Lane mask.
        send(1, 0, 4'b0101, 4'd5);
        n = 1;
        wait_valid(n);
        check("t4_mask_z", out_z, {32'h0, 32'h3E800000, 32'h0, 32'h3E800000});

        // Flush with three beats in flight.
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) send(i, 1, 4'hF, 4'(1 + i));
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("t5_flush_inflight", {125'b0, inflight}, 0);
        check("t5_flush_valid", {127'b0, out_valid}, 0);
        send(7, 0, 4'hF, 4'd9);
        n = 1;
        wait_valid(n);
        check("t5_latency", DW'(n), DW'(5));
        check("t5_z", out_z, {4{32'h3FC00000}});
        check("t5_id", {124'b0, out_id}, 9);

        // Divide by zero, then reset mid-stream.
        send(4, 0, 4'hF, 4'd2);
        n = 1;
        wait_valid(n);
        check("t6_inf_lane1", {96'b0, out_z[63:32]}, {96'b0, 32'h7F800000});
`ifdef FP_DIV_STATUS_EN
        check("t6_dz_any", {127'b0, out_dz_any}, 1);
`endif
        send(0, 1, 4'hF, 4'd4);
        send(3, 1, 4'hF, 4'd6);
        rst_n = 1'b0;
        #1;
        check("t6_reset_valid", {127'b0, out_valid}, 0);
        check("t6_reset_inflight", {125'b0, inflight}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("t6_after_reset", {127'b0, out_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
